// File: rtl/fire_control_scheduler_pkg.sv
// Shared types and constants for the magazine fire-control scheduler.
// Holds the FSM state encoding and the mode value that enables firing.
package fire_control_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRE   = 2'd1,
        ST_COOL   = 2'd2,
        ST_RELOAD = 2'd3
    } fcs_state_t;

    localparam logic [3:0] ATTACK_MODE = 4'b0010;

    function automatic logic is_attack(input logic [3:0] mode);
        return mode == ATTACK_MODE;
    endfunction

endpackage

// File: rtl/fire_control_scheduler_rr_arbiter.sv
// Combinational round-robin picker: the search begins one past the last
// winner and wraps, so a requester that just fired has the lowest priority.
module fire_control_scheduler_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_ptr,
    output logic             o_valid,
    output logic [N_REQ-1:0] o_onehot,
    output logic [IW-1:0]    o_idx
);

    int          w_cand;
    logic [IW-1:0] w_sel;

    always_comb begin
        o_valid  = 1'b0;
        o_onehot = '0;
        o_idx    = '0;
        w_cand   = 0;
        w_sel    = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            w_cand = (int'(i_ptr) + off) % N_REQ;
            w_sel  = IW'(w_cand);
            if (!o_valid && i_req[w_sel]) begin
                o_valid         = 1'b1;
                o_onehot[w_sel] = 1'b1;
                o_idx           = w_sel;
            end
        end
    end

endmodule

// File: rtl/fire_control_scheduler.sv
// Magazine sequencer: one shot at a time in round-robin order, attack-mode
// gating, post-shot cooldown, and a timed reload that refills to capacity.
module fire_control_scheduler
    import fire_control_scheduler_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int W             = 9,
    parameter int MAG_CAP       = 300,
    parameter int COOLDOWN      = 4,
    parameter int RELOAD_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       mode,
    input  logic [N_REQ-1:0] fire_req,
    input  logic [W-1:0]     shot_cost,
    input  logic             reload_req,
    output logic [N_REQ-1:0] grant,
    output logic             shot,
    output logic [W-1:0]     ammo,
    output logic             error,
    output logic             reloading,
    output logic             reload_done,
    output fcs_state_t       o_dbg_state
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = 16;

    fcs_state_t       r_state;
    logic [CW-1:0]    r_cnt;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_win_idx;
    logic [W-1:0]     r_ammo;
    logic [N_REQ-1:0] r_grant;
    logic             r_shot;
    logic             r_error;
    logic             r_reloading;
    logic             r_reload_done;

    logic             w_win_valid;
    logic [N_REQ-1:0] w_win_onehot;
    logic [IW-1:0]    w_win_idx;
    logic             w_fire_ok;

    fire_control_scheduler_rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr_arbiter (
        .i_req    (fire_req),
        .i_ptr    (r_ptr),
        .o_valid  (w_win_valid),
        .o_onehot (w_win_onehot),
        .o_idx    (w_win_idx)
    );

    // The affordability check guards the debit, so ammo can never wrap.
    assign w_fire_ok = is_attack(mode) && (r_ammo >= shot_cost);

    // Handshake: fire_req is a level held by the turret until it sees its
    // grant bit; grant/shot are single-cycle pulses; reload_req is a level
    // looked at only while idle, and reload_done marks the first idle cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_ptr         <= IW'(N_REQ - 1);
            r_win_idx     <= '0;
            r_ammo        <= '0;
            r_grant       <= '0;
            r_shot        <= 1'b0;
            r_error       <= 1'b0;
            r_reloading   <= 1'b0;
            r_reload_done <= 1'b0;
        end else begin
            r_grant       <= '0;
            r_shot        <= 1'b0;
            r_error       <= 1'b0;
            r_reload_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (reload_req) begin
                        r_state     <= ST_RELOAD;
                        r_cnt       <= CW'(RELOAD_CYCLES - 1);
                        r_reloading <= 1'b1;
                    end else if (w_win_valid && w_fire_ok) begin
                        r_state   <= ST_FIRE;
                        r_grant   <= w_win_onehot;
                        r_shot    <= 1'b1;
                        r_win_idx <= w_win_idx;
                        r_ammo    <= r_ammo - shot_cost;
                    end else if (w_win_valid) begin
                        r_error <= 1'b1;
                    end
                end
                ST_FIRE: begin
                    r_ptr   <= r_win_idx;
                    r_cnt   <= CW'(COOLDOWN - 1);
                    r_state <= ST_COOL;
                end
                ST_COOL: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RELOAD: begin
                    if (r_cnt == '0) begin
                        r_state       <= ST_IDLE;
                        r_reloading   <= 1'b0;
                        r_ammo        <= W'(MAG_CAP);
                        r_reload_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant       = r_grant;
    assign shot        = r_shot;
    assign ammo        = r_ammo;
    assign error       = r_error;
    assign reloading   = r_reloading;
    assign reload_done = r_reload_done;
    assign o_dbg_state = r_state;

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(r_grant));
    a_shot_matches: assert property (@(posedge clk) disable iff (!rst) r_shot == (|r_grant));
    a_ammo_bound:   assert property (@(posedge clk) disable iff (!rst) r_ammo <= W'(MAG_CAP));

endmodule

// File: doc/fire_control_scheduler.md
# fire_control_scheduler

Sequencer and arbiter for the shared ammunition magazine. Up to N_REQ turret requesters contend for one magazine; the block grants one shot at a time in round-robin order. It enforces attack-mode gating and a post-shot cooldown, debits the per-shot cost from the ammo count, and runs a timed reload sequence that refills the magazine to capacity. It sits between the turret request logic and the magazine counter and is the single writer of the ammo count.

## Interface
- N_REQ, 4, number of requesters (2..8)
- W, 9, ammo count width
- MAG_CAP, 300, magazine capacity loaded on reload (< 2^W)
- COOLDOWN, 4, idle cycles enforced after each shot (≥1)
- RELOAD_CYCLES, 8, duration of reload sequence (≥1)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- mode  in  4  operating mode; 4'b0010 = attack
- fire_req  in  N_REQ  level request per turret; held until granted
- shot_cost  in  W  ammo consumed per shot, sampled at grant decision
- reload_req  in  1  level request to start reload
- grant  out  N_REQ  one-hot, one cycle, registered
- shot  out  1  one-cycle pulse coincident with grant
- ammo  out  W  current magazine count, registered
- error  out  1  one-cycle pulse: denied fire attempt
- reloading  out  1  high throughout RELOAD state
- reload_done  out  1  one-cycle pulse on reload completion

## Operation
- States: IDLE, FIRE, COOL, RELOAD.
- IDLE, priority order:
  - reload_req=1 → RELOAD; load counter with RELOAD_CYCLES-1.
  - Else any fire_req, mode==attack, and ammo ≥ shot_cost (unsigned, W bits) → FIRE. Latch winner one-hot; ammo ← ammo − shot_cost on the same edge.
  - Else any fire_req and (mode≠attack or ammo < shot_cost) → error=1 next cycle, stay IDLE. error repeats every cycle while the condition persists.
  - shot_cost=0 is legal: grant issued, ammo unchanged.
- FIRE: grant=winner, shot=1 for exactly one cycle. Round-robin pointer ← winner index. Counter ← COOLDOWN-1. → COOL.
- COOL: decrement; at 0 → IDLE. Requests, reload_req and mode changes are ignored (no error, no grant); a mode change mid-cooldown does not abort it.
- RELOAD: reloading=1; decrement; at 0 → IDLE with ammo ← MAG_CAP and reload_done=1 on the following cycle. fire_req during reload produces no error; it is served after return to IDLE. reload_req is level-sampled only in IDLE; holding it high re-triggers reload.
- Round-robin: search starts at (pointer+1) mod N_REQ, wrapping; pointer updates only on an actual grant.
- Ammo never underflows: the decrement only occurs after the ≥ check.

## Timing
- Reset (rst=0, async): state=IDLE, ammo=0, grant=0, shot=0, error=0, reloading=0, reload_done=0, pointer=N_REQ-1 (requester 0 has first priority). Outputs settle without a clock edge.
- Request sampled at edge e0 → grant/shot high during cycle e0..e1, ammo already updated in that cycle.
- Minimum grant spacing: COOLDOWN+2 cycles (FIRE + COOLDOWN + IDLE sample).
- Reload: reload_req sampled at e0 → reloading high for RELOAD_CYCLES cycles. ammo=MAG_CAP and reload_done high in the first IDLE cycle. Earliest grant follows one cycle later.
- error is a registered pulse one cycle after the sampling edge.
- Reset asserted mid-FIRE/COOL/RELOAD aborts immediately to reset values; a partial reload does not refill.

## Structure
- Shared package: state encoding (IDLE/FIRE/COOL/RELOAD, 2 bits), ATTACK_MODE=4'b0010 constant.
- Sub-module rr_arbiter: N_REQ requests + pointer → one-hot winner + index; purely combinational. FSM, counters and ammo register stay in the top.

## Test plan
- Reset, reload_req pulse with RELOAD_CYCLES=8 → reloading high 8 cycles, then ammo=300, reload_done one cycle.
- mode=attack, ammo=300, fire_req=4'b1111 held, shot_cost=7 → grants 0001,0010,0100,1000,0001 every 6 cycles; ammo 293,286,279,272,265.
- mode=4'b0001, fire_req=4'b0100 → no grant, error pulses each IDLE cycle, ammo unchanged.
- ammo=5, shot_cost=7, attack → error, no grant; then reload → next request granted, ammo=293.
- reload_req and fire_req asserted the same cycle in IDLE → RELOAD wins, no error; fire granted after reload_done.
- rst dropped mid-RELOAD at cycle 4 → all outputs 0, ammo=0, state IDLE; no reload_done.
